// File: rtl/conway_board_scanner_if.sv
// Handshake/data bundle between the board scanner and its rule/control side.
// The slave modport is the scanner view; master is the driver view.
interface conway_board_scanner_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int N = ROWS * COLS;

  logic         load_en;
  logic [N-1:0] load_board;
  logic         step;
  logic [7:0]   neighbors;
  logic         cell_state;
  logic         next_state;
  logic         cell_valid;
  logic [4:0]   cell_row;
  logic [4:0]   cell_col;
  logic [N-1:0] board;
  logic         busy;
  logic         done;

  modport slave (
    input  load_en, load_board, step, next_state,
    output neighbors, cell_state, cell_valid,
    output cell_row, cell_col, board, busy, done
  );

  modport master (
    output load_en, load_board, step, next_state,
    input  neighbors, cell_state, cell_valid,
    input  cell_row, cell_col, board, busy, done
  );
endinterface

// File: rtl/conway_board_scanner.sv
// Row-major Life board scanner; external rule supplies each next cell.
// Define CONWAY_WRAP_EN for a toroidal board, else the edge reads dead.
module conway_board_scanner #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input logic clk,
  input logic rst,
  conway_board_scanner_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [4:0] R_LAST = 5'(ROWS - 1);
  localparam logic [4:0] C_LAST = 5'(COLS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t state, state_nx;

  logic [4:0]   row, col;
  logic [N-1:0] board_q, shadow_q, shadow_nx;
  logic [AW-1:0] cur_idx;
  logic          last_cell, scan;
  logic [4:0]   rn, rs, cw, ce;
  logic          rn_ok, rs_ok, cw_ok, ce_ok;
  logic [7:0]   nb;

  function automatic logic [AW-1:0] idx(
    input logic [4:0] r,
    input logic [4:0] c
  );
    return AW'(int'(r) * COLS + int'(c));
  endfunction

  assign scan      = (state == SCAN);
  assign cur_idx   = idx(row, col);
  assign last_cell = (row == R_LAST) && (col == C_LAST);

  // Off-board neighbours keep an in-range index and are masked by *_ok.
  always_comb begin
`ifdef CONWAY_WRAP_EN
    rn_ok = 1'b1;
    rs_ok = 1'b1;
    cw_ok = 1'b1;
    ce_ok = 1'b1;
    rn = (row == 5'd0) ? R_LAST : row - 5'd1;
    rs = (row == R_LAST) ? 5'd0 : row + 5'd1;
    cw = (col == 5'd0) ? C_LAST : col - 5'd1;
    ce = (col == C_LAST) ? 5'd0 : col + 5'd1;
`else
    rn_ok = (row != 5'd0);
    rs_ok = (row != R_LAST);
    cw_ok = (col != 5'd0);
    ce_ok = (col != C_LAST);
    rn = rn_ok ? row - 5'd1 : row;
    rs = rs_ok ? row + 5'd1 : row;
    cw = cw_ok ? col - 5'd1 : col;
    ce = ce_ok ? col + 5'd1 : col;
`endif
  end

  always_comb begin
    nb    = '0;
    nb[0] = rn_ok & cw_ok & board_q[idx(rn, cw)];
    nb[1] = rn_ok &         board_q[idx(rn, col)];
    nb[2] = rn_ok & ce_ok & board_q[idx(rn, ce)];
    nb[3] =         cw_ok & board_q[idx(row, cw)];
    nb[4] =         ce_ok & board_q[idx(row, ce)];
    nb[5] = rs_ok & cw_ok & board_q[idx(rs, cw)];
    nb[6] = rs_ok &         board_q[idx(rs, col)];
    nb[7] = rs_ok & ce_ok & board_q[idx(rs, ce)];
  end

  assign bus.neighbors  = scan ? nb : 8'h00;
  assign bus.cell_state = scan & board_q[cur_idx];
  assign bus.cell_valid = scan;
  assign bus.cell_row   = scan ? row : 5'd0;
  assign bus.cell_col   = scan ? col : 5'd0;
  assign bus.board      = board_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == COMMIT);

  always_comb begin
    shadow_nx          = shadow_q;
    shadow_nx[cur_idx] = bus.next_state;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!bus.load_en && bus.step) state_nx = SCAN;
      SCAN:    if (last_cell) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The board takes the merged shadow as SCAN ends so it shows during COMMIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      row      <= 5'd0;
      col      <= 5'd0;
      board_q  <= '0;
      shadow_q <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          row <= 5'd0;
          col <= 5'd0;
          if (bus.load_en) board_q <= bus.load_board;
        end
        SCAN: begin
          shadow_q <= shadow_nx;
          if (last_cell) begin
            board_q <= shadow_nx;
            row     <= 5'd0;
            col     <= 5'd0;
          end else if (col == C_LAST) begin
            col <= 5'd0;
            row <= row + 5'd1;
          end else begin
            col <= col + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/conway_board_scanner.md
CONWAY_BOARD_SCANNER -- requirements
Module: conway_board_scanner

Interface
REQ-001 Parameter ROWS, default 8: board height in cells (legal range 3..32).
REQ-002 Parameter COLS, default 8: board width in cells (legal range 3..32).
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 load_en  input  1: board load request, sampled in IDLE only.
REQ-006 load_board  input  ROWS*COLS: board image; cell (r,c) at bit r*COLS+c; 1 = alive.
REQ-007 step  input  1: request one generation, sampled in IDLE only.
REQ-008 neighbors  output  8: neighbor bits of current cell, [0]=NW [1]=N [2]=NE [3]=W [4]=E [5]=SW [6]=S [7]=SE.
REQ-009 cell_state  output  1: current value of the cell being scanned.
REQ-010 next_state  input  1: external rule result for presented cell, combinational, same cycle.
REQ-011 cell_valid  output  1: neighbors/cell_state valid, high only in SCAN.
REQ-012 cell_row  output  5, cell_col  output  5: coordinates of current cell.
REQ-013 board  output  ROWS*COLS: committed board, same bit mapping as load_board.
REQ-014 busy  output  1: high in SCAN and COMMIT.
REQ-015 done  output  1: one-cycle pulse when new generation is committed.

Function
REQ-016 FSM states IDLE, SCAN, COMMIT; the block SHALL be in IDLE after reset.
REQ-017 IDLE with load_en=1: board <= load_board next edge; step ignored that cycle (load wins).
REQ-018 IDLE with step=1, load_en=0: enter SCAN, index reset to (0,0).
REQ-019 SCAN: one cell per cycle, row-major, (0,0) first, (ROWS-1,COLS-1) last; cell_valid=1 throughout.
REQ-020 SCAN: each cycle, next_state SHALL be captured into shadow bit of the presented cell; committed board SHALL NOT change during SCAN.
REQ-021 SCAN -> COMMIT after last cell; COMMIT lasts exactly one cycle: board <= shadow, done=1, then IDLE.
REQ-022 Latency: step sampled at edge 0 -> cell (0,0) presented cycle 1 -> done high and new board visible cycle ROWS*COLS+1 -> IDLE cycle ROWS*COLS+2.
REQ-023 step and load_en while busy SHALL be ignored, not queued.
REQ-024 Outside SCAN: neighbors=0, cell_state=0, cell_row=0, cell_col=0, cell_valid=0.
REQ-025 Neighbor coordinates SHALL be computed as row±1, col±1 with edge handling per REQ-032/REQ-033; no out-of-range board index SHALL be generated.

Reset
REQ-026 rst low SHALL asynchronously force: state IDLE, board=0, shadow=0, index=(0,0), busy=0, done=0, cell_valid=0.
REQ-027 Reset asserted mid-SCAN or in COMMIT SHALL abort the generation; no partial commit; board stays 0 after release.
REQ-028 First step/load_en SHALL be honored on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro CONWAY_WRAP_EN selects edge topology; exactly this one feature is configurable.
REQ-030 Both variants SHALL have identical ports, timing and FSM.
REQ-031 Edge handling applies per-axis, independently for rows and columns.
REQ-032 With CONWAY_WRAP_EN defined: toroidal board; row -1 maps to ROWS-1, row ROWS to 0; likewise columns.
REQ-033 Without CONWAY_WRAP_EN: neighbors outside the board SHALL read as 0 (dead boundary).

Verification
REQ-034 8x8, load blinker (3,2),(3,3),(3,4), standard rule as next_state, step -> done at cycle 65 after step edge; board = (2,3),(3,3),(4,3) only.
REQ-035 8x8, single live cell (0,0), scan cell (7,7) -> neighbors=8'h80 (SE=1) with CONWAY_WRAP_EN; 8'h00 without.
REQ-036 8x8, cell (0,0) presented first cycle after step with cell_row=0, cell_col=0; cell (7,7) presented cycle 64; cell_valid high exactly 64 cycles.
REQ-037 Assert step and load_en during SCAN -> no effect; done still at cycle 65; board = computed generation, not load_board.
REQ-038 Assert rst at SCAN cycle 20 -> board=0, busy=0 immediately; release, step -> all-dead board, done after 65 cycles.
REQ-039 IDLE, load_en=1 and step=1 same cycle -> board = load_board, busy stays 0.
